// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one shared g-function/XOR-chain path
// produces round keys 0..NUM_ROUNDS, each released through a valid/ready handshake.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS  = 10,
    parameter bit EMIT_ROUND0 = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_abort,
    input  logic [127:0] i_key,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    output logic [127:0] o_rk,
    output logic [3:0]   o_rk_idx,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic         o_busy,
    output logic         o_done
);

    // state | meaning
    // IDLE  | waiting for a cipher key (key_ready high)
    // GCALC | g-function of the last word of the current key into r_g
    // XOR   | word XOR chain builds the next round key, bumps index and rcon
    // EMIT  | round key presented; held until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_GCALC, S_XOR, S_EMIT} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(11'd2047 - {x, 3'b000}) -: 8];
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_rk;
    logic [3:0]   r_rk_idx;
    logic [7:0]   r_rcon;
    logic [31:0]  r_g;
    logic         r_done;
    logic         w_key_acc;
    logic         w_done_nxt;
    logic [31:0]  w_g;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_rcon_nxt;

    // RotWord then SubWord of w3, with rcon folded into the top byte.
    assign w_g = {sbox(r_rk[23:16]) ^ r_rcon, sbox(r_rk[15:8]),
                  sbox(r_rk[7:0]), sbox(r_rk[31:24])};

    assign w_n0 = r_rk[127:96] ^ r_g;
    assign w_n1 = r_rk[95:64]  ^ w_n0;
    assign w_n2 = r_rk[63:32]  ^ w_n1;
    assign w_n3 = r_rk[31:0]   ^ w_n2;

    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    always_comb begin
        w_state_nxt = r_state;
        w_key_acc   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_key_valid) begin
                    w_key_acc   = !i_abort;
                    w_state_nxt = EMIT_ROUND0 ? S_EMIT : S_GCALC;
                end
            end
            S_GCALC: w_state_nxt = S_XOR;
            S_XOR:   w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (i_rk_ready) begin
                    if (r_rk_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = !i_abort;
                    end else begin
                        w_state_nxt = S_GCALC;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush beats any handshake or key accept in the same cycle.
        if (i_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_rk     <= '0;
            r_rk_idx <= '0;
            r_rcon   <= 8'h01;
            r_g      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_key_acc) begin
                r_rk     <= i_key;
                r_rcon   <= 8'h01;
                r_rk_idx <= '0;
            end
            if (r_state == S_GCALC) r_g <= w_g;
            if (r_state == S_XOR) begin
                r_rk     <= {w_n0, w_n1, w_n2, w_n3};
                r_rk_idx <= r_rk_idx + 4'd1;
                r_rcon   <= w_rcon_nxt;
            end
        end
    end

    assign o_key_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_rk_valid  = (r_state == S_EMIT);
    assign o_rk        = r_rk;
    assign o_rk_idx    = r_rk_idx;
    assign o_done      = r_done;

endmodule
